controlpath_mc: RTL
===================

CONTROLPATH_MC -- requirements
Module: controlpath_mc

Interface
REQ-001 SHALL: parameter STATE_W, default 5, state register width; must be at least 5.
REQ-002 SHALL: parameter MEM_TIMEOUT, default 15, maximum wait cycles on mem_ready before abort; range 1..255.
REQ-003 SHALL: parameter HALT_OPC, default 4'b1111, opcode that halts the machine.
REQ-004 SHALL: clk  in  1  single clock; all state changes occur on posedge clk only.
REQ-005 SHALL: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL: IR  in  16  current instruction register contents.
REQ-007 SHALL: N, Z, P  in  1 each  condition codes from the datapath.
REQ-008 SHALL: mem_ready  in  1  memory completion strobe, one cycle per access.
REQ-009 SHALL: mem_req, mem_we  out  1  memory request, and write qualifier for that request.
REQ-010 SHALL: marE, pcE, mdrE, irE, regWriteE, nzpE  out  1  register enables, each valid for one clock.
REQ-011 SHALL: marmux, adjmux, mdrControl, mdrmux, srmux, drmux, lshift  out  1  datapath selects.
REQ-012 SHALL: pcmux, regmux, opmux  out  2, and aluControl  out  3, with the existing datapath encodings.
REQ-013 SHALL: halted, illegal, timeout_err  out  1  status flags; state  out  STATE_W  current state.

Function
REQ-014 SHALL: use one registered state; all outputs are combinational decodes of state and IR, and of mem_ready only where stated.
REQ-015 SHALL: use these state encodings: FETCH0=0, FETCH1=1, FETCH2=2, DECODE=3, ALU=4, REGCCW=5, BR=8, LD0=9, LD1=10, ST0=12, ST1=13, ST2=14, JMP=17, JSR0=18, JSR1=19, JSR2=20, LEA=21, SHF=22, HALT=23, ILL=24, TOUT=25.
REQ-016 SHALL: in FETCH0, assert marE with marmux=0, then go to FETCH1.
REQ-017 SHALL: in FETCH1, assert mem_req with mem_we=0, hold until mem_ready=1; on that cycle assert mdrE, mdrmux=1, pcE with pcmux=00, then go to FETCH2.
REQ-018 SHALL: in FETCH2, assert irE, then go to DECODE.
REQ-019 SHALL: in DECODE, dispatch on IR[15:12]: 0001/0101/1001 to ALU; 0000 to BR; 1100 to JMP; 0100 to JSR0; 0010/0110 to LD0; 0011/0111 to ST0; 1110 to LEA; 1101 to SHF; HALT_OPC to HALT; 1000/1010/1011 to ILL.
REQ-020 SHALL: in ALU, set regmux=10, srmux=1, opmux=00 if IR[5]=0 else 10, and aluControl 000/001/010 for ADD/AND/XOR; then go to REGCCW.
REQ-021 SHALL: in REGCCW, assert regWriteE and nzpE with drmux=0, then go to FETCH0.
REQ-022 SHALL: in BR, set pcmux=10, adjmux=1, and pcE=(IR[11]&N)|(IR[10]&Z)|(IR[9]&P); then go to FETCH0.
REQ-023 SHALL: in LD0 and ST0, assert marE with marmux=1, opmux=11, aluControl=000, srmux=1, and lshift=mdrControl=IR[14].
REQ-024 SHALL: in LD1, assert mem_req (mem_we=0), wait for mem_ready; on it, assert mdrE with mdrmux=1 and regmux=00; then go to REGCCW.
REQ-025 SHALL: in ST1, assert mdrE with mdrmux=0, srmux=0, aluControl=110.
REQ-026 SHALL: in ST2, assert mem_req with mem_we=1, wait for mem_ready, then go to FETCH0.
REQ-027 SHALL: JMP, JSR0-2, LEA and SHF keep the existing datapath encodings.
REQ-028 SHALL: in JSR2, assert pcE whether IR[11]=0 (register target) or IR[11]=1 (pcmux=10, adjmux=0).
REQ-029 SHALL: SHF with IR[5:4]=10 is illegal and goes to ILL.
REQ-030 SHALL: maintain a wait counter that clears on entering any mem_req state and increments each cycle mem_ready=0.
REQ-031 SHALL: when the counter reaches MEM_TIMEOUT, go to TOUT and set sticky timeout_err; mem_ready arriving on that same cycle wins and no timeout occurs.
REQ-032 SHALL: ILL sets sticky illegal for one access and returns to FETCH0 without any register write.
REQ-033 SHALL: HALT sets halted=1 and holds; only reset exits HALT.
REQ-034 SHALL: TOUT holds until reset.
REQ-035 SHALL: never assert two memory requests in one cycle; mem_we=1 only in ST2.

Reset
REQ-036 SHALL: when reset=1 at posedge, set state to FETCH0, clear the wait counter, halted, illegal and timeout_err.
REQ-037 SHALL: force all enables and mem_req to 0 during any cycle with reset=1, including a reset applied mid-access, which aborts the access.

Verification
REQ-038 SHALL: ADD with IR=16'h1283 and mem_ready on first FETCH1 cycle -> states 0,1,2,3,4,5,0; regWriteE and nzpE for 1 cycle in state 5.
REQ-039 SHALL: BR with IR=16'h0405 and Z=1, N=P=0 -> pcE=1 in state 8; with Z=0 -> pcE=0.
REQ-040 SHALL: STW with mem_ready delayed 3 cycles in ST2 -> mem_req and mem_we high for 4 cycles, then FETCH0.
REQ-041 SHALL: LDW with mem_ready never asserted -> TOUT after exactly 15 wait cycles, timeout_err=1; reset clears it and restarts at FETCH0.
REQ-042 SHALL: IR=16'hA000 -> ILL, illegal=1, no regWriteE.
REQ-043 SHALL: IR=16'hF000 -> HALT, halted=1, state stays 23 for 20 cycles.

Source files
------------

// File: rtl/controlpath_mc.sv
// controlpath_mc -- multicycle control path for a 16-bit load/store datapath.
// One registered state selects every datapath control. Controls are decoded
// combinationally from state and IR, and from mem_ready only in memory-wait states.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   IR, N, Z, P, mem_ready     instruction, condition codes, memory completion strobe
//   mem_req, mem_we            memory request and its write qualifier
//   marE..nzpE                 one-cycle register enables
//   marmux..aluControl         datapath selects
//   halted, illegal,
//   timeout_err                sticky status flags; state = current state
module controlpath_mc #(
    parameter int unsigned STATE_W     = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter logic [3:0]  HALT_OPC    = 4'b1111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        IR,
    input  logic               N,
    input  logic               Z,
    input  logic               P,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               marE,
    output logic               pcE,
    output logic               mdrE,
    output logic               irE,
    output logic               regWriteE,
    output logic               nzpE,
    output logic               marmux,
    output logic               adjmux,
    output logic               mdrControl,
    output logic               mdrmux,
    output logic               srmux,
    output logic               drmux,
    output logic               lshift,
    output logic [1:0]         pcmux,
    output logic [1:0]         regmux,
    output logic [1:0]         opmux,
    output logic [2:0]         aluControl,
    output logic               halted,
    output logic               illegal,
    output logic               timeout_err,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH0 = STATE_W'(0),  FETCH1 = STATE_W'(1),  FETCH2 = STATE_W'(2),
        DECODE = STATE_W'(3),  ALU    = STATE_W'(4),  REGCCW = STATE_W'(5),
        BR     = STATE_W'(8),  LD0    = STATE_W'(9),  LD1    = STATE_W'(10),
        ST0    = STATE_W'(12), ST1    = STATE_W'(13), ST2    = STATE_W'(14),
        JMP    = STATE_W'(17), JSR0   = STATE_W'(18), JSR1   = STATE_W'(19),
        JSR2   = STATE_W'(20), LEA    = STATE_W'(21), SHF    = STATE_W'(22),
        HALT   = STATE_W'(23), ILL    = STATE_W'(24), TOUT   = STATE_W'(25)
    } state_t;

    state_t     cur;
    logic [7:0] wait_cnt;
    logic       mem_state;
    logic       expire;

    assign state     = cur;
    assign mem_state = (cur == FETCH1) || (cur == LD1) || (cur == ST2);
    // The MEM_TIMEOUT-th consecutive cycle without mem_ready aborts the access;
    // a mem_ready on that same cycle still completes it.
    assign expire    = mem_state && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

    // HALT_OPC is checked first so it overrides the fixed opcode map.
    function automatic state_t decode_op(input logic [15:0] ir);
        state_t d;
        if (ir[15:12] == HALT_OPC) begin
            d = HALT;
        end else begin
            case (ir[15:12])
                4'b0001, 4'b0101, 4'b1001: d = ALU;
                4'b0000:                   d = BR;
                4'b1100:                   d = JMP;
                4'b0100:                   d = JSR0;
                4'b0010, 4'b0110:          d = LD0;
                4'b0011, 4'b0111:          d = ST0;
                4'b1110:                   d = LEA;
                4'b1101:                   d = (ir[5:4] == 2'b10) ? ILL : SHF;
                default:                   d = ILL;
            endcase
        end
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= FETCH0;
            wait_cnt    <= '0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            case (cur)
                FETCH0: begin cur <= FETCH1; wait_cnt <= '0; end
                FETCH1: begin
                    if (mem_ready)   cur <= FETCH2;
                    else if (expire) begin cur <= TOUT; timeout_err <= 1'b1; end
                end
                FETCH2: cur <= DECODE;
                DECODE: begin
                    cur <= decode_op(IR);
                    if (decode_op(IR) == ILL)  illegal <= 1'b1;
                    if (decode_op(IR) == HALT) halted  <= 1'b1;
                end
                ALU:    cur <= REGCCW;
                REGCCW: cur <= FETCH0;
                BR:     cur <= FETCH0;
                LD0:    begin cur <= LD1; wait_cnt <= '0; end
                LD1: begin
                    if (mem_ready)   cur <= REGCCW;
                    else if (expire) begin cur <= TOUT; timeout_err <= 1'b1; end
                end
                ST0:    cur <= ST1;
                ST1:    begin cur <= ST2; wait_cnt <= '0; end
                ST2: begin
                    if (mem_ready)   cur <= FETCH0;
                    else if (expire) begin cur <= TOUT; timeout_err <= 1'b1; end
                end
                JMP:    cur <= FETCH0;
                JSR0:   cur <= JSR1;
                JSR1:   cur <= JSR2;
                JSR2:   cur <= FETCH0;
                LEA:    cur <= REGCCW;
                SHF:    cur <= REGCCW;
                ILL:    cur <= FETCH0;
                HALT:   cur <= HALT;
                TOUT:   cur <= TOUT;
                default: cur <= FETCH0;
            endcase
        end
    end

    always_comb begin
        mem_req = 1'b0; mem_we = 1'b0;
        marE = 1'b0; pcE = 1'b0; mdrE = 1'b0; irE = 1'b0; regWriteE = 1'b0; nzpE = 1'b0;
        marmux = 1'b0; adjmux = 1'b0; mdrControl = 1'b0; mdrmux = 1'b0;
        srmux = 1'b0; drmux = 1'b0; lshift = 1'b0;
        pcmux = 2'b00; regmux = 2'b00; opmux = 2'b00; aluControl = 3'b000;
        case (cur)
            FETCH0: begin marE = 1'b1; marmux = 1'b0; end
            FETCH1: begin
                mem_req = 1'b1;
                if (mem_ready) begin mdrE = 1'b1; mdrmux = 1'b1; pcE = 1'b1; pcmux = 2'b00; end
            end
            FETCH2: irE = 1'b1;
            ALU: begin
                regmux = 2'b10; srmux = 1'b1;
                opmux  = IR[5] ? 2'b10 : 2'b00;
                case (IR[15:12])
                    4'b0101: aluControl = 3'b001;
                    4'b1001: aluControl = 3'b010;
                    default: aluControl = 3'b000;
                endcase
            end
            REGCCW: begin regWriteE = 1'b1; nzpE = 1'b1; drmux = 1'b0; end
            BR: begin
                pcmux = 2'b10; adjmux = 1'b1;
                pcE   = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
            end
            LD0, ST0: begin
                marE = 1'b1; marmux = 1'b1; opmux = 2'b11; aluControl = 3'b000; srmux = 1'b1;
                lshift = IR[14]; mdrControl = IR[14];
            end
            LD1: begin
                mem_req = 1'b1;
                if (mem_ready) begin mdrE = 1'b1; mdrmux = 1'b1; regmux = 2'b00; end
            end
            ST1: begin mdrE = 1'b1; mdrmux = 1'b0; srmux = 1'b0; aluControl = 3'b110; end
            ST2: begin mem_req = 1'b1; mem_we = 1'b1; end
            JMP: begin pcE = 1'b1; pcmux = 2'b01; end
            // JSR0 parks the base-register target in MAR, JSR1 links PC into R7,
            // JSR2 loads PC from MAR (register form) or PC+offset (IR[11]=1).
            JSR0: begin marE = 1'b1; marmux = 1'b1; srmux = 1'b1; opmux = 2'b11; aluControl = 3'b111; end
            JSR1: begin regWriteE = 1'b1; drmux = 1'b1; regmux = 2'b11; end
            JSR2: begin pcE = 1'b1; pcmux = IR[11] ? 2'b10 : 2'b11; adjmux = 1'b0; end
            LEA:  begin regmux = 2'b01; adjmux = 1'b1; end
            SHF: begin
                regmux = 2'b10; srmux = 1'b1; opmux = 2'b01;
                case (IR[5:4])
                    2'b01:   aluControl = 3'b100;
                    2'b11:   aluControl = 3'b101;
                    default: aluControl = 3'b011;
                endcase
            end
            default: ;
        endcase
        // Reset kills any in-flight access and all register writes that cycle.
        if (reset) begin
            mem_req = 1'b0; mem_we = 1'b0;
            marE = 1'b0; pcE = 1'b0; mdrE = 1'b0; irE = 1'b0; regWriteE = 1'b0; nzpE = 1'b0;
        end
    end

endmodule
